// File: rtl/pulse_scheduler.sv
// Burst sequencer for the pulsed-sine transmit path: gates the sine output and
// strobes the NCO phase reset at each pulse, timed in ms from a per-burst config.
module pulse_scheduler #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned MS_W     = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [MS_W-1:0]  pw_ms_i,
    input  logic [MS_W-1:0]  pri_ms_i,
    input  logic [CNT_W-1:0] num_pulses_i,
    output logic             tx_en_o,
    output logic             phase_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pulse_idx_o
);

    localparam int unsigned TICKS_PER_MS = CLK_FREQ / 1000;
    localparam int unsigned TICK_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_e;

    state_e            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [MS_W-1:0]   ms_q;
    logic [MS_W-1:0]   pw_q;
    logic [MS_W-1:0]   pri_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  idx_q;
    logic              tx_en_q;
    logic              phase_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              cfg_ok;
    logic              ms_edge;
    logic              on_end;
    logic              off_end;
    logic              more_pulses;
    logic [CNT_W-1:0]  idx_d;

    assign cfg_ok  = (pw_ms_i != '0) && (pri_ms_i != '0) && (pw_ms_i < pri_ms_i);
    assign ms_edge = (tick_q == TICK_LAST);

    // The ms counter runs across the whole period: 0..pw-1 is ON, pw..pri-1 is OFF.
    assign on_end      = ms_edge && (ms_q == pw_q - MS_W'(1));
    assign off_end     = ms_edge && (ms_q == pri_q - MS_W'(1));
    assign idx_d       = idx_q + CNT_W'(1);
    assign more_pulses = (num_q == '0) || (idx_d < num_q);

    // NOTE: state and outputs share one clocked block with non-blocking
    // assignments, so every output is a flop and strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            ms_q        <= '0;
            pw_q        <= '0;
            pri_q       <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            tx_en_q     <= 1'b0;
            phase_rst_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            phase_rst_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        if (cfg_ok) begin
                            pw_q        <= pw_ms_i;
                            pri_q       <= pri_ms_i;
                            num_q       <= num_pulses_i;
                            idx_q       <= '0;
                            tick_q      <= '0;
                            ms_q        <= '0;
                            state_q     <= S_ON;
                            tx_en_q     <= 1'b1;
                            phase_rst_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                S_ON, S_OFF: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        tx_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        tick_q <= ms_edge ? '0 : tick_q + TICK_W'(1);
                        if (ms_edge) begin
                            ms_q <= ms_q + MS_W'(1);
                        end

                        if (state_q == S_ON && on_end) begin
                            state_q <= S_OFF;
                            tx_en_q <= 1'b0;
                        end else if (state_q == S_OFF && off_end) begin
                            if (more_pulses) begin
                                state_q     <= S_ON;
                                tx_en_q     <= 1'b1;
                                phase_rst_q <= 1'b1;
                                idx_q       <= idx_d;
                                tick_q      <= '0;
                                ms_q        <= '0;
                            end else begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_en_o     = tx_en_q;
    assign phase_rst_o = phase_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pulse_idx_o = idx_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler at 10 clk/ms: burst timing, config
// rejection, continuous mode with abort, mid-burst disturbance and reset.
module tb_pulse_scheduler;

    localparam int unsigned CLK_FREQ = 10000;
    localparam int unsigned MS_W     = 16;
    localparam int unsigned CNT_W    = 16;
    localparam int          TPM      = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             abort_i;
    logic [MS_W-1:0]  pw_ms_i;
    logic [MS_W-1:0]  pri_ms_i;
    logic [CNT_W-1:0] num_pulses_i;
    logic             tx_en_o;
    logic             phase_rst_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] pulse_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_scheduler #(
        .CLK_FREQ(CLK_FREQ),
        .MS_W    (MS_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .pw_ms_i     (pw_ms_i),
        .pri_ms_i    (pri_ms_i),
        .num_pulses_i(num_pulses_i),
        .tx_en_o     (tx_en_o),
        .phase_rst_o (phase_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .pulse_idx_o (pulse_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed view {idx, tx, phase_rst, busy, done, err} for one-shot comparison.
    function automatic logic [31:0] pack(input logic tx, input logic prst, input logic busy,
                                         input logic done, input logic err, input int idx);
        logic [15:0] i16;
        i16 = 16'(idx);
        return {i16, 11'b0, tx, prst, busy, done, err};
    endfunction

    function automatic logic [31:0] observed();
        return pack(tx_en_o, phase_rst_o, busy_o, done_o, err_o, int'(pulse_idx_o));
    endfunction

    // Expected outputs k cycles after the cycle in which start was sampled (k>=1).
    function automatic logic [31:0] model(input int pw, input int pri, input int num, input int k);
        int p_len;
        int on_len;
        int p;
        int ph;
        p_len  = pri * TPM;
        on_len = pw * TPM;
        p      = (k - 1) / p_len;
        ph     = (k - 1) % p_len;
        if (num != 0 && p >= num)
            return pack(1'b0, 1'b0, 1'b0, (k == num * p_len + 1), 1'b0, num - 1);
        return pack(ph < on_len, ph == 0, 1'b1, 1'b0, 1'b0, p);
    endfunction

    task automatic run_burst(input string tag, input int pw, input int pri, input int num,
                             input int ncyc, input bit disturb, output int pulses);
        logic prev_tx;
        pulses       = 0;
        prev_tx      = 1'b0;
        pw_ms_i      = MS_W'(pw);
        pri_ms_i     = MS_W'(pri);
        num_pulses_i = CNT_W'(num);
        start_i      = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            check($sformatf("%s_k%0d", tag, k), observed(), model(pw, pri, num, k));
            if (tx_en_o && !prev_tx) pulses++;
            prev_tx = tx_en_o;
            start_i = disturb && (k == 5 || k == 30 || k == 60);
            if (disturb && k == 5) begin
                pw_ms_i      = 16'd1;
                pri_ms_i     = 16'd3;
                num_pulses_i = 16'd7;
            end
        end
        start_i = 1'b0;
    endtask

    int pulses;

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        pw_ms_i      = '0;
        pri_ms_i     = '0;
        num_pulses_i = '0;
        repeat (3) @(negedge clk);
        check("reset_state", observed(), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", observed(), 32'h0);

        // Three-pulse burst: 20 clk on, 30 clk off, done at cycle 151.
        run_burst("s1", 2, 5, 3, 152, 1'b0, pulses);
        check("s1_pulses", pulses, 3);

        // Rejected configurations: err strobe only, index holds from last burst.
        begin
            int bad_pw[4]  = '{5, 0, 3, 4};
            int bad_pri[4] = '{5, 5, 0, 3};
            for (int i = 0; i < 4; i++) begin
                pw_ms_i      = MS_W'(bad_pw[i]);
                pri_ms_i     = MS_W'(bad_pri[i]);
                num_pulses_i = 16'd3;
                start_i      = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                check($sformatf("s2_err_%0d", i), observed(), pack(0, 0, 0, 0, 1, 2));
                @(negedge clk);
                check($sformatf("s2_after_%0d", i), observed(), pack(0, 0, 0, 0, 0, 2));
            end
        end

        // Continuous mode, 1 ms on / 2 ms period, then abort during ON.
        run_burst("s3", 1, 2, 0, 1000, 1'b0, pulses);
        check("s3_pulses", pulses, 50);
        @(negedge clk);
        check("s3_k1001_on", observed(), model(1, 2, 0, 1001));
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("s3_abort_flags", observed() & 32'h1F, 32'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check($sformatf("s3_post_abort_%0d", i), observed() & 32'h1F, 32'h0);
        end

        // Inputs change and start pulses mid-burst; latched timing must hold.
        run_burst("s4", 2, 5, 2, 102, 1'b1, pulses);
        check("s4_pulses", pulses, 2);

        // Start and abort together in IDLE: nothing starts.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_reset", observed(), 32'h0);
        pw_ms_i      = 16'd2;
        pri_ms_i     = 16'd5;
        num_pulses_i = 16'd3;
        start_i      = 1'b1;
        abort_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("s5_start_abort", observed(), 32'h0);
        @(negedge clk);
        check("s5_start_abort_hold", observed(), 32'h0);

        // Reset 7 clk into the first ON phase.
        start_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            check($sformatf("s5_pre_k%0d", k), observed(), model(2, 5, 3, k));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_rst_mid", observed(), 32'h0);
        @(negedge clk);
        check("s5_rst_idle", observed(), 32'h0);

        run_burst("s5b", 2, 5, 3, 152, 1'b0, pulses);
        check("s5b_pulses", pulses, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
